// File: rtl/tile_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tile_seq_ctrl
//
// Sequences one tile pass of the core datapath:
//   1. WLOAD   : stream `col` weight words from weight SRAM into L0
//   2. KLOAD   : pop `col` words out of L0 into the PE array (inst_w = 01)
//   3. KSETTLE : KWAIT quiet cycles so the kernel load settles in the array
//   4. XLOAD   : stream `nij` activation words from activation SRAM into L0
//   5. EXEC    : pop `nij` words from L0 (inst_w = 10) while concurrently
//                draining OFIFO results into psum SRAM
//   6. DONE    : one-cycle done pulse, then back to IDLE
// A pass with nij == 0 skips XLOAD and EXEC entirely.
//
// Ports:
//   clk, reset            clock; asynchronous active-low reset
//   start                 1-cycle pulse, accepted only while idle
//   w_base/x_base/
//   psum_base/nij         pass configuration, latched on an accepted start
//   busy, done            pass in progress / 1-cycle end-of-pass pulse
//   w_cen/w_wen/w_addr    weight SRAM port (active-low enables, read only)
//   x_cen/x_wen/x_addr    activation SRAM port (active-low enables, read only)
//   psum_cen/psum_wen/
//   psum_addr             psum SRAM port (active-low enables, write only)
//   l0_src                L0 input mux select: 0 = weight Q, 1 = activation Q
//   l0_wr, l0_rd          L0 push / pop
//   inst_w                PE array instruction: 01 kernel load, 10 execute
//   l0_full, l0_ready     L0 full / L0 non-empty
//   ofifo_rd              OFIFO pop (OFIFO head is show-ahead)
//   ofifo_valid           OFIFO head valid
//
// SRAM reads have one cycle of latency, so a read issued in cycle t is only
// written into L0 in cycle t+1 or later. The `pending` flag marks a read
// whose data sits on the SRAM Q and still has to be pushed into L0; the SRAM
// Q holds that word for as long as no new read is issued, which is why a new
// read is only issued once the pending word can leave in the same cycle.
// ---------------------------------------------------------------------------
module tile_seq_ctrl #(
    parameter int row         = 8,
    parameter int col         = 8,
    parameter int W_ADDR_W    = 8,
    parameter int X_ADDR_W    = 10,
    parameter int PSUM_ADDR_W = 14,
    parameter int NIJ_W       = 10,
    parameter int KWAIT       = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [W_ADDR_W-1:0]    w_base,
    input  logic [X_ADDR_W-1:0]    x_base,
    input  logic [PSUM_ADDR_W-1:0] psum_base,
    input  logic [NIJ_W-1:0]       nij,
    output logic                   busy,
    output logic                   done,
    output logic                   w_cen,
    output logic                   w_wen,
    output logic [W_ADDR_W-1:0]    w_addr,
    output logic                   x_cen,
    output logic                   x_wen,
    output logic [X_ADDR_W-1:0]    x_addr,
    output logic                   psum_cen,
    output logic                   psum_wen,
    output logic [PSUM_ADDR_W-1:0] psum_addr,
    output logic                   l0_src,
    output logic                   l0_wr,
    output logic                   l0_rd,
    output logic [1:0]             inst_w,
    input  logic                   l0_full,
    input  logic                   l0_ready,
    output logic                   ofifo_rd,
    input  logic                   ofifo_valid
);

    // -----------------------------------------------------------------------
    // Sizing
    // -----------------------------------------------------------------------
    // One counter width serves both the weight phase (counts to col) and the
    // activation phase (counts to nij).
    localparam int COL_W    = $clog2(col + 1);
    localparam int CNT_W    = (NIJ_W > COL_W) ? NIJ_W : COL_W;
    localparam int SETTLE_W = (KWAIT > 1) ? $clog2(KWAIT + 1) : 1;

    localparam logic [CNT_W-1:0]    COL_C       = CNT_W'(col);
    localparam logic [CNT_W-1:0]    COL_LAST    = CNT_W'(col - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(KWAIT - 1);

    // -----------------------------------------------------------------------
    // FSM encoding
    // -----------------------------------------------------------------------
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WLOAD   = 3'd1;
    localparam logic [2:0] S_KLOAD   = 3'd2;
    localparam logic [2:0] S_KSETTLE = 3'd3;
    localparam logic [2:0] S_XLOAD   = 3'd4;
    localparam logic [2:0] S_EXEC    = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [2:0]             state;
    logic [2:0]             state_next;

    logic [W_ADDR_W-1:0]    w_base_q;
    logic [X_ADDR_W-1:0]    x_base_q;
    logic [PSUM_ADDR_W-1:0] psum_base_q;
    logic [NIJ_W-1:0]       nij_q;

    logic [CNT_W-1:0]       ld_cnt;      // reads issued in the current load phase
    logic                   pending;     // a read result waits on the SRAM Q
    logic [CNT_W-1:0]       pop_cnt;     // L0 pops in KLOAD or EXEC
    logic [CNT_W-1:0]       drain_cnt;   // OFIFO words moved to psum SRAM
    logic [SETTLE_W-1:0]    settle_cnt;  // cycles spent in KSETTLE

    // -----------------------------------------------------------------------
    // Load engine (shared by WLOAD and XLOAD)
    // -----------------------------------------------------------------------
    logic             ld_active;
    logic [CNT_W-1:0] ld_total;
    logic             ld_issue;
    logic             ld_write;
    logic             pending_next;
    logic             ld_last;
    logic [CNT_W-1:0] nij_ext;

    assign nij_ext   = CNT_W'(nij_q);
    assign ld_active = (state == S_WLOAD) || (state == S_XLOAD);
    assign ld_total  = (state == S_WLOAD) ? COL_C : nij_ext;

    // A new read may go out when nothing is waiting on the Q, or when the
    // waiting word is pushed into L0 in this very cycle.
    assign ld_issue     = ld_active && (ld_cnt < ld_total) && (!pending || !l0_full);
    assign ld_write     = ld_active && pending && !l0_full;
    assign pending_next = ld_issue || (pending && l0_full);

    // All reads issued and nothing left waiting after this cycle.
    assign ld_last = ld_active && (ld_cnt == ld_total) && !(pending && l0_full);

    // -----------------------------------------------------------------------
    // Pop / drain engines
    // -----------------------------------------------------------------------
    logic             kpop;
    logic             xpop;
    logic             drain;
    logic [CNT_W-1:0] pop_after;
    logic [CNT_W-1:0] drain_after;
    logic             exec_end;

    assign kpop  = (state == S_KLOAD) && l0_ready && (pop_cnt < COL_C);
    assign xpop  = (state == S_EXEC)  && l0_ready && (pop_cnt < nij_ext);
    assign drain = (state == S_EXEC)  && ofifo_valid && (drain_cnt < nij_ext);

    // Counts as they will stand after this cycle; used to leave EXEC on the
    // same edge that completes the last pop/drain.
    assign pop_after   = pop_cnt + CNT_W'(xpop);
    assign drain_after = drain_cnt + CNT_W'(drain);
    assign exec_end    = (state == S_EXEC) && (pop_after == nij_ext)
                         && (drain_after == nij_ext);

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_WLOAD;
                end
            end
            S_WLOAD: begin
                if (ld_last) begin
                    state_next = S_KLOAD;
                end
            end
            S_KLOAD: begin
                if (kpop && (pop_cnt == COL_LAST)) begin
                    state_next = S_KSETTLE;
                end
            end
            S_KSETTLE: begin
                if (settle_cnt == SETTLE_LAST) begin
                    // An empty activation set has nothing to stream or drain.
                    state_next = (nij_q == '0) ? S_DONE : S_XLOAD;
                end
            end
            S_XLOAD: begin
                if (ld_last) begin
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                if (exec_end) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Sequential state
    // -----------------------------------------------------------------------
    logic phase_change;
    assign phase_change = (state_next != state);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            w_base_q    <= '0;
            x_base_q    <= '0;
            psum_base_q <= '0;
            nij_q       <= '0;
            ld_cnt      <= '0;
            pending     <= 1'b0;
            pop_cnt     <= '0;
            drain_cnt   <= '0;
            settle_cnt  <= '0;
        end else begin
            state <= state_next;

            // Configuration is captured only when a pass is accepted, so
            // changes on these inputs mid-pass have no effect.
            if ((state == S_IDLE) && start) begin
                w_base_q    <= w_base;
                x_base_q    <= x_base;
                psum_base_q <= psum_base;
                nij_q       <= nij;
            end

            // Every counter restarts from zero on entry to a new phase.
            if (phase_change) begin
                ld_cnt     <= '0;
                pending    <= 1'b0;
                pop_cnt    <= '0;
                drain_cnt  <= '0;
                settle_cnt <= '0;
            end else begin
                ld_cnt    <= ld_cnt + CNT_W'(ld_issue);
                pending   <= ld_active ? pending_next : 1'b0;
                pop_cnt   <= pop_cnt + CNT_W'(kpop || xpop);
                drain_cnt <= drain_after;
                if (state == S_KSETTLE) begin
                    settle_cnt <= settle_cnt + 1'b1;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    logic w_issue;
    logic x_issue;

    assign w_issue = (state == S_WLOAD) && ld_issue;
    assign x_issue = (state == S_XLOAD) && ld_issue;

    always_comb begin
        busy      = (state != S_IDLE);
        done      = (state == S_DONE);

        // Weight and activation SRAMs are only ever read.
        w_cen     = !w_issue;
        w_wen     = 1'b1;
        w_addr    = '0;
        x_cen     = !x_issue;
        x_wen     = 1'b1;
        x_addr    = '0;

        // psum SRAM is only ever written, in lock-step with OFIFO pops.
        psum_cen  = !drain;
        psum_wen  = !drain;
        psum_addr = '0;

        l0_src    = (state == S_XLOAD);
        l0_wr     = ld_write;
        l0_rd     = kpop || xpop;
        inst_w    = 2'b00;
        ofifo_rd  = drain;

        // Addresses wrap naturally at their own width.
        if (w_issue) begin
            w_addr = w_base_q + W_ADDR_W'(ld_cnt);
        end
        if (x_issue) begin
            x_addr = x_base_q + X_ADDR_W'(ld_cnt);
        end
        if (drain) begin
            psum_addr = psum_base_q + PSUM_ADDR_W'(drain_cnt);
        end

        if (kpop) begin
            inst_w = 2'b01;
        end else if (xpop) begin
            inst_w = 2'b10;
        end
    end

endmodule

// File: tb/tb_tile_seq_ctrl.sv
module tb_tile_seq_ctrl;

    localparam int COL   = 8;
    localparam int KWAIT = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  w_base = '0;
    logic [9:0]  x_base = '0;
    logic [13:0] psum_base = '0;
    logic [9:0]  nij = '0;
    logic        busy, done;
    logic        w_cen, w_wen, x_cen, x_wen, psum_cen, psum_wen;
    logic [7:0]  w_addr;
    logic [9:0]  x_addr;
    logic [13:0] psum_addr;
    logic        l0_src, l0_wr, l0_rd, ofifo_rd;
    logic [1:0]  inst_w;
    logic        l0_full = 1'b0;
    logic        l0_ready = 1'b0;
    logic        ofifo_valid = 1'b0;

    tile_seq_ctrl dut (
        .clk(clk), .reset(reset), .start(start),
        .w_base(w_base), .x_base(x_base), .psum_base(psum_base), .nij(nij),
        .busy(busy), .done(done),
        .w_cen(w_cen), .w_wen(w_wen), .w_addr(w_addr),
        .x_cen(x_cen), .x_wen(x_wen), .x_addr(x_addr),
        .psum_cen(psum_cen), .psum_wen(psum_wen), .psum_addr(psum_addr),
        .l0_src(l0_src), .l0_wr(l0_wr), .l0_rd(l0_rd), .inst_w(inst_w),
        .l0_full(l0_full), .l0_ready(l0_ready),
        .ofifo_rd(ofifo_rd), .ofifo_valid(ofifo_valid)
    );

    always #5 clk = ~clk;

    // SRAM contents are a function of the address so pushed data reveals
    // which word was read.
    function automatic logic [15:0] wword(input int a);
        logic [7:0] aa;
        aa = 8'(a);
        return {8'hA5, aa};
    endfunction
    function automatic logic [15:0] xword(input int a);
        logic [9:0] aa;
        aa = 10'(a);
        return {6'h2C, aa};
    endfunction

    logic [15:0] w_q = '0;
    logic [15:0] x_q = '0;
    logic [15:0] l0_din;
    always @(posedge clk) begin
        if (!w_cen && w_wen) w_q <= wword(int'(w_addr));
        if (!x_cen && x_wen) x_q <= xword(int'(x_addr));
    end
    assign l0_din = l0_src ? x_q : w_q;

    // ---------------- checking bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- behavioural model (progress counts) ----------------
    int m_active = 0;
    int m_wr, m_wp, m_kp, m_st, m_xr, m_xp, m_ep, m_dr;
    int m_wbase, m_xbase, m_pbase, m_nij;
    int passes_done = 0;
    int exec_idx;
    int act_pushes;
    int last_kpop_cyc, first_xread_cyc, done_cyc;
    int waddr_log[$];
    int wread_cyc[$];
    int xaddr_log[$];
    int paddr_log[$];
    int psum_cyc[$];
    int psum_exec_idx[$];
    logic [15:0] l0q[$];

    // 0 idle, 1 weight load, 2 kernel load, 3 settle, 4 act load, 5 execute, 6 done
    function automatic int phase();
        if (m_active == 0) return 0;
        if (m_wp < COL) return 1;
        if (m_kp < COL) return 2;
        if (m_st < KWAIT) return 3;
        if (m_nij > 0 && m_xp < m_nij) return 4;
        if (m_nij > 0 && (m_ep < m_nij || m_dr < m_nij)) return 5;
        return 6;
    endfunction

    always @(negedge clk) begin
        int ph;
        bit e_wiss, e_xiss, e_wr, e_rd, e_ofr;
        logic [1:0] e_inst;
        cyc++;
        if (!reset) begin
            m_active = 0;
            l0q.delete();
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_cen", {w_cen, x_cen, psum_cen}, 3'b111);
            chk("rst_wen", {w_wen, x_wen, psum_wen}, 3'b111);
            chk("rst_l0", {l0_wr, l0_rd, l0_src, ofifo_rd}, 4'b0000);
            chk("rst_inst", inst_w, 0);
            chk("rst_addr", {w_addr, x_addr, psum_addr}, 0);
        end else begin
            ph     = phase();
            e_wiss = (ph == 1) && (m_wr < COL) && ((m_wr == m_wp) || !l0_full);
            e_xiss = (ph == 4) && (m_xr < m_nij) && ((m_xr == m_xp) || !l0_full);
            e_wr   = (((ph == 1) && (m_wr > m_wp)) || ((ph == 4) && (m_xr > m_xp))) && !l0_full;
            e_rd   = l0_ready && ((ph == 2) || ((ph == 5) && (m_ep < m_nij)));
            e_inst = !e_rd ? 2'b00 : ((ph == 2) ? 2'b01 : 2'b10);
            e_ofr  = (ph == 5) && ofifo_valid && (m_dr < m_nij);

            chk("busy", busy, m_active != 0);
            chk("done", done, ph == 6);
            chk("w_cen", w_cen, !e_wiss);
            chk("x_cen", x_cen, !e_xiss);
            chk("wen_rd_only", {w_wen, x_wen}, 2'b11);
            chk("l0_wr", l0_wr, e_wr);
            chk("l0_rd", l0_rd, e_rd);
            chk("inst_w", inst_w, e_inst);
            chk("ofifo_rd", ofifo_rd, e_ofr);
            chk("psum_en", {psum_cen, psum_wen}, {!e_ofr, !e_ofr});

            if (e_wiss) begin
                chk("w_addr", w_addr, (m_wbase + m_wr) % 256);
                waddr_log.push_back(int'(w_addr));
                wread_cyc.push_back(cyc);
            end
            if (e_xiss) begin
                chk("x_addr", x_addr, (m_xbase + m_xr) % 1024);
                if (m_xr == 0) first_xread_cyc = cyc;
                xaddr_log.push_back(int'(x_addr));
            end
            if (e_ofr) begin
                chk("psum_addr", psum_addr, (m_pbase + m_dr) % 16384);
                paddr_log.push_back(int'(psum_addr));
                psum_cyc.push_back(cyc);
                psum_exec_idx.push_back(exec_idx);
            end
            if (e_wr && l0_wr) begin
                chk("l0_src", l0_src, ph == 4);
                chk("l0_data", l0_din, (ph == 1) ? wword(m_wbase + m_wp) : xword(m_xbase + m_xp));
            end

            // L0 occupancy follows what the DUT actually did
            if (l0_wr) begin
                l0q.push_back(l0_din);
                act_pushes++;
            end
            if (l0_rd && l0q.size() > 0) void'(l0q.pop_front());

            // progress update
            if (ph == 0 && start) begin
                m_active = 1;
                m_wbase = int'(w_base); m_xbase = int'(x_base);
                m_pbase = int'(psum_base); m_nij = int'(nij);
                m_wr = 0; m_wp = 0; m_kp = 0; m_st = 0;
                m_xr = 0; m_xp = 0; m_ep = 0; m_dr = 0;
                exec_idx = 0; act_pushes = 0;
                last_kpop_cyc = -1; first_xread_cyc = -1; done_cyc = -1;
                waddr_log.delete(); wread_cyc.delete(); xaddr_log.delete();
                paddr_log.delete(); psum_cyc.delete(); psum_exec_idx.delete();
            end
            if (e_wiss) m_wr++;
            if (e_xiss) m_xr++;
            if (ph == 1 && e_wr) m_wp++;
            if (ph == 4 && e_wr) m_xp++;
            if (ph == 2 && e_rd) begin m_kp++; last_kpop_cyc = cyc; end
            if (ph == 3) m_st++;
            if (ph == 5) begin
                if (e_rd) m_ep++;
                if (e_ofr) m_dr++;
                exec_idx++;
            end
            if (ph == 6) begin
                m_active = 0;
                passes_done++;
                done_cyc = cyc;
            end
        end
    end

    // ---------------- stimulus ----------------
    bit full_force = 0;
    bit rnd_full   = 0;
    bit rnd_ready  = 0;
    int ofv_mode   = 0;   // 0 always valid, 1 random, 2 fixed pattern
    bit pat[7] = '{1, 0, 0, 1, 1, 0, 1};

    task automatic step();
        @(posedge clk);
        #1;
        l0_full  = full_force || (rnd_full && $urandom_range(0, 3) == 0);
        l0_ready = (l0q.size() > 0) && (!rnd_ready || $urandom_range(0, 2) != 0);
        case (ofv_mode)
            0: ofifo_valid = 1'b1;
            1: ofifo_valid = ($urandom_range(0, 1) == 1);
            default: ofifo_valid = (phase() == 5 && exec_idx < 7) ? pat[exec_idx] : 1'b0;
        endcase
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic set_cfg(input int wb, input int xb, input int pb, input int n);
        w_base = 8'(wb); x_base = 10'(xb); psum_base = 14'(pb); nij = 10'(n);
    endtask

    task automatic wait_done(input string name);
        int p0, k;
        p0 = passes_done;
        k = 0;
        while (passes_done == p0 && k < 3000) begin
            step();
            k++;
        end
        chk({name, "_complete"}, passes_done - p0, 1);
        step();
        step();
    endtask

    task automatic run_pass(input string name, input int wb, input int xb, input int pb, input int n);
        set_cfg(wb, xb, pb, n);
        pulse_start();
        wait_done(name);
        $display("pass %s: w_base=0x%0h x_base=0x%0h psum_base=0x%0h nij=%0d pushes=%0d psum_writes=%0d",
                 name, wb, xb, pb, n, act_pushes, paddr_log.size());
    endtask

    task automatic wait_phase(input string name, input int ph);
        int k;
        k = 0;
        while (phase() != ph && k < 500) begin
            step();
            k++;
        end
        chk(name, phase(), ph);
    endtask

    initial begin
        int n;
        reset = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        step();

        // nominal pass
        run_pass("nominal", 'h10, 0, 'h100, 4);
        chk("nom_wreads", waddr_log.size(), 8);
        if (waddr_log.size() == 8) begin
            chk("nom_wfirst", waddr_log[0], 'h10);
            chk("nom_wlast", waddr_log[7], 'h17);
            chk("nom_wconsec", wread_cyc[7] - wread_cyc[0], 7);
        end
        chk("nom_settle", first_xread_cyc - last_kpop_cyc - 1, 16);
        chk("nom_xreads", xaddr_log.size(), 4);
        if (xaddr_log.size() == 4) chk("nom_xlast", xaddr_log[3], 3);
        chk("nom_pwrites", paddr_log.size(), 4);
        if (paddr_log.size() == 4) begin
            chk("nom_pfirst", paddr_log[0], 'h100);
            chk("nom_plast", paddr_log[3], 'h103);
        end
        chk("nom_busy_after", busy, 0);

        // l0_full stall mid weight load
        set_cfg('h40, 'h20, 'h200, 2);
        pulse_start();
        begin
            int k;
            k = 0;
            while (m_wp < 3 && k < 100) begin step(); k++; end
        end
        full_force = 1; l0_full = 1'b1;
        repeat (4) step();
        full_force = 0;
        wait_done("stall");
        chk("stall_wreads", waddr_log.size(), 8);
        chk("stall_pushes", act_pushes, 10);

        // ofifo_valid pattern
        ofv_mode = 2;
        run_pass("ofifo_pat", 'h00, 'h30, 'h300, 4);
        chk("ofp_writes", psum_exec_idx.size(), 4);
        if (psum_exec_idx.size() == 4) begin
            chk("ofp_idx0", psum_exec_idx[0], 0);
            chk("ofp_idx1", psum_exec_idx[1], 3);
            chk("ofp_idx2", psum_exec_idx[2], 4);
            chk("ofp_idx3", psum_exec_idx[3], 6);
            chk("ofp_done_gap", done_cyc - psum_cyc[3], 1);
            chk("ofp_addr3", paddr_log[3], 'h303);
        end
        ofv_mode = 0;

        // nij = 0
        run_pass("nij0", 'h80, 'h55, 'h10, 0);
        chk("nij0_xreads", xaddr_log.size(), 0);
        chk("nij0_pwrites", paddr_log.size(), 0);
        chk("nij0_done_gap", done_cyc - last_kpop_cyc - 1, 16);
        chk("nij0_pushes", act_pushes, 8);

        // activation address wrap
        run_pass("xwrap", 'hFC, 'h3FE, 'h3FFE, 4);
        chk("xwrap_n", xaddr_log.size(), 4);
        if (xaddr_log.size() == 4) begin
            chk("xwrap_a0", xaddr_log[0], 'h3FE);
            chk("xwrap_a1", xaddr_log[1], 'h3FF);
            chk("xwrap_a2", xaddr_log[2], 'h000);
            chk("xwrap_a3", xaddr_log[3], 'h001);
        end
        if (paddr_log.size() == 4) chk("pwrap_a2", paddr_log[2], 'h0000);

        // start while busy, then reset during EXEC
        set_cfg('h20, 'h40, 'h500, 6);
        pulse_start();
        wait_phase("reach_xload", 4);
        set_cfg('h99, 'h155, 'h77, 3);
        pulse_start();
        wait_phase("reach_exec", 5);
        step();
        #2 reset = 1'b0;
        #1;
        chk("async_busy", busy, 0);
        chk("async_cen", {w_cen, x_cen, psum_cen}, 3'b111);
        chk("async_l0", {l0_wr, l0_rd, ofifo_rd, inst_w}, 5'b00000);
        chk("async_addr", {w_addr, x_addr, psum_addr}, 0);
        repeat (2) step();
        reset = 1'b1;
        step();
        run_pass("post_reset", 'h08, 'h10, 'h20, 5);
        chk("post_wreads", waddr_log.size(), 8);
        chk("post_pwrites", paddr_log.size(), 5);
        if (paddr_log.size() == 5) chk("post_pfirst", paddr_log[0], 'h20);

        // randomized passes
        rnd_full = 1; rnd_ready = 1; ofv_mode = 1;
        for (int i = 0; i < 8; i++) begin
            n = $urandom_range(0, 20);
            run_pass("random", $urandom_range(0, 255), $urandom_range(0, 1023),
                     $urandom_range(0, 16383), n);
            chk("rnd_pushes", act_pushes, 8 + n);
            chk("rnd_pwrites", paddr_log.size(), n);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish (got timeout, expected completion)");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/tile_seq_ctrl.md
Name: tile_seq_ctrl

Overview:
Sequences one tile pass of the core datapath. It reads weights from weight SRAM into L0, loads kernels into the PE array, streams activations through L0 in execute mode, and drains the OFIFO into psum SRAM. It sits between the host/testbench and the core's SRAM and corelet control pins, replacing hand-sequenced stimulus. Top level wires l0_din from w_q or x_q per l0_src, and psum_d from ofifo_dout.

Parameters:
row, 8, PE rows; width of one weight/activation word in bw-bit lanes
col, 8, PE columns; number of weight words per kernel load
W_ADDR_W, 8, weight SRAM address width
X_ADDR_W, 10, activation SRAM address width
PSUM_ADDR_W, 14, psum SRAM address width
NIJ_W, 10, width of the nij count
KWAIT, 16, idle cycles after kernel load before activation streaming

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
start  in  1  1-cycle pulse; begin pass when idle
w_base  in  W_ADDR_W  first weight word address
x_base  in  X_ADDR_W  first activation word address
psum_base  in  PSUM_ADDR_W  first psum write address
nij  in  NIJ_W  activation vectors (= psum words) this pass
busy  out  1  pass in progress
done  out  1  1-cycle pulse at pass end
w_cen, w_wen  out  1 each  weight SRAM enables, active-low
w_addr  out  W_ADDR_W  weight SRAM address
x_cen, x_wen  out  1 each  activation SRAM enables, active-low
x_addr  out  X_ADDR_W  activation SRAM address
psum_cen, psum_wen  out  1 each  psum SRAM enables, active-low
psum_addr  out  PSUM_ADDR_W  psum SRAM address
l0_src  out  1  0: l0_din=w_q, 1: l0_din=x_q
l0_wr, l0_rd  out  1 each  L0 push/pop
inst_w  out  2  01 kernel load, 10 execute, 00 idle
l0_full, l0_ready  in  1 each  L0 full / L0 non-empty
ofifo_rd  out  1  OFIFO pop
ofifo_valid  in  1  OFIFO head valid; ofifo_dout is show-ahead

Behaviour:
- Reset (async assert, low) takes effect immediately, including mid-pass. After reset: state IDLE, all CEN/WEN=1, all addresses 0, l0_wr=l0_rd=ofifo_rd=0, inst_w=00, l0_src=0, busy=0, done=0, all counters and pending=0.
- start and bases/nij are sampled only in IDLE. start during busy is ignored.
- FSM: IDLE -> WLOAD -> KLOAD -> KSETTLE -> XLOAD -> EXEC -> DONE -> IDLE. busy=1 in every state except IDLE.
- IDLE -> WLOAD on the cycle after start. nij is latched at start.
- SRAM reads take 1 cycle. The read issued at t with CEN=0, WEN=1 gives Q at t+1. Q holds while no new read is issued.
- Load engine (WLOAD: count col, w_*, l0_src=0; XLOAD: count nij, x_*, l0_src=1):
  - issue = (remaining>0) & (!pending | !l0_full)
  - l0_wr = pending & !l0_full
  - pending_next = issue | (pending & l0_full)
  - Address = base + issued count, mod 2^width (wraps).
  - Phase ends when all words are written and pending=0. Back-to-back rate is 1 word/cycle.
- KLOAD: l0_rd=1 with inst_w=01 on each cycle l0_ready=1, until col pops. No pop when l0_ready=0.
- KSETTLE: exactly KWAIT cycles with inst_w=00, no SRAM or L0 activity.
- nij==0: KSETTLE -> DONE directly, skipping XLOAD and EXEC.
- EXEC:
  - l0_rd=1 with inst_w=10 whenever l0_ready=1, until nij pops.
  - Drain runs concurrently: ofifo_rd = ofifo_valid & (drained<nij).
  - Same cycle as each pop: psum_cen=0, psum_wen=0, psum_addr=psum_base+drained (wraps).
  - EXEC -> DONE when drained==nij and all nij L0 pops are done.
- DONE: done=1 for exactly one cycle, then IDLE. busy drops in IDLE.
- inst_w is 00 whenever l0_rd=0.
- l0_wr and l0_rd are never asserted in the same cycle.
- The controller never writes weight or activation SRAMs (w_wen=x_wen=1 always) and never reads psum SRAM.

Test Plan:
- Nominal, w_base=0x10, x_base=0, psum_base=0x100, nij=4, no stalls -> weight reads at 0x10..0x17 on 8 consecutive cycles; 8 l0_wr; 8 cycles l0_rd, inst_w=01; 16 idle cycles; 4 x reads at 0..3; 4 execute pops; 4 psum writes at 0x100..0x103; done pulses once; busy low after.
- l0_full held high 5 cycles mid-WLOAD -> no new reads and no l0_wr during the stall; the held word is written once l0_full drops; no word lost or duplicated; 8 total l0_wr.
- ofifo_valid toggling 1,0,0,1,1,0,1 with nij=4 -> ofifo_rd and psum writes only on valid cycles; addresses contiguous from psum_base; done after the 4th write.
- nij=0 -> weight and kernel phases run; no x reads, no psum writes; done right after KSETTLE.
- x_base=0x3FE, nij=4 -> x_addr sequence 0x3FE, 0x3FF, 0x000, 0x001.
- reset low during EXEC, and start pulsed during busy -> outputs return to reset values immediately; a subsequent start runs a clean pass; the start pulsed while busy has no effect.
